// File: rtl/circ_tap_ctrl.sv
// rtl/circ_tap_ctrl.sv - circular-buffer write/rotate controller for a clock-gated tap bank
// One sample writes one bank slot; bank contents are rotated back into newest-first taps.
module circ_tap_ctrl #(
  parameter int LENGTH = 16,
  parameter int WIDTH  = 8,
  localparam int PTR_W = $clog2(LENGTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_sample,
  input  logic                      flush,
  output logic [LENGTH-1:0]         cg_en,
  output logic [LENGTH*WIDTH-1:0]   reg_in,
  input  logic [LENGTH*WIDTH-1:0]   reg_out,
  output logic [LENGTH*WIDTH-1:0]   taps_out,
  output logic                      taps_valid,
  output logic                      filled,
  output logic [PTR_W-1:0]          wr_ptr
);

  localparam int FILL_W = $clog2(LENGTH + 1);
  localparam logic [PTR_W-1:0]  LAST = PTR_W'(LENGTH - 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(LENGTH);

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    pending_q, pending_d;
  logic [LENGTH*WIDTH-1:0] taps_q, taps_d;
  logic                    taps_valid_q, taps_valid_d;
  logic                    filled_q, filled_d;

  // Enable is gated by reset so the bank cannot be written while reset is held.
  always_comb begin
    cg_en = '0;
    if (!reset) begin
      cg_en = '0;
    end else if (flush) begin
      cg_en = '1;
    end else if (in_valid) begin
      cg_en[wr_ptr_q] = 1'b1;
    end
    reg_in = flush ? '0 : {LENGTH{in_sample}};
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    pending_d    = 1'b0;
    taps_d       = taps_q;
    taps_valid_d = 1'b0;
    filled_d     = (fill_q == FULL);

    // wr_ptr_q has already advanced past the newest sample's slot.
    if (pending_q) begin
      for (int k = 0; k < LENGTH; k++) begin
        taps_d[k*WIDTH +: WIDTH] =
          reg_out[((int'(wr_ptr_q) + 2*LENGTH - 1 - k) % LENGTH) * WIDTH +: WIDTH];
      end
      taps_valid_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d     = '0;
      fill_d       = '0;
      pending_d    = 1'b0;
      taps_d       = '0;
      taps_valid_d = 1'b0;
      filled_d     = 1'b0;
    end else if (in_valid) begin
      wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      fill_d    = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      pending_q    <= 1'b0;
      taps_q       <= '0;
      taps_valid_q <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      pending_q    <= pending_d;
      taps_q       <= taps_d;
      taps_valid_q <= taps_valid_d;
      filled_q     <= filled_d;
    end
  end

  assign taps_out   = taps_q;
  assign taps_valid = taps_valid_q;
  assign filled     = filled_q;
  assign wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_circ_tap_ctrl.sv
// tb/tb_circ_tap_ctrl.sv - directed vectors on a 4-tap instance, random reference run on 16 taps
module tb_circ_tap_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_sample = '0;

  logic [3:0]   cg4;
  logic [31:0]  rin4, rout4, taps4;
  logic         tv4, f4;
  logic [1:0]   wp4;

  logic [15:0]  cg16;
  logic [127:0] rin16, rout16, taps16;
  logic         tv16, f16;
  logic [3:0]   wp16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  circ_tap_ctrl #(.LENGTH(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample), .flush(flush),
    .cg_en(cg4), .reg_in(rin4), .reg_out(rout4), .taps_out(taps4),
    .taps_valid(tv4), .filled(f4), .wr_ptr(wp4)
  );

  circ_tap_ctrl #(.LENGTH(16), .WIDTH(8)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample), .flush(flush),
    .cg_en(cg16), .reg_in(rin16), .reg_out(rout16), .taps_out(taps16),
    .taps_valid(tv16), .filled(f16), .wr_ptr(wp16)
  );

  // Clock-gated register banks driven by the controllers
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rout4  <= '0;
      rout16 <= '0;
    end else begin
      for (int i = 0; i < 4; i++)  if (cg4[i])  rout4[8*i +: 8]  <= rin4[8*i +: 8];
      for (int i = 0; i < 16; i++) if (cg16[i]) rout16[8*i +: 8] <= rin16[8*i +: 8];
    end
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic        fl;
    logic [7:0]  s;
    logic [3:0]  cg;
    logic [1:0]  wp;
    logic [31:0] taps;
    logic        tv;
    logic        f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic iv, logic fl, logic [7:0] s, logic [3:0] cg,
                              logic [1:0] wp, logic [31:0] taps, logic tv, logic f);
    vec_t v;
    v.rst = rst; v.iv = iv; v.fl = fl; v.s = s; v.cg = cg;
    v.wp = wp; v.taps = taps; v.tv = tv; v.f = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; in_sample = '0;
    #2;
    reset = 1'b1;
  endtask

  logic [127:0] m_hist, m_taps;
  logic         m_pend, m_tv, m_filled;
  int           m_cnt;

  initial begin
    // samples 1,2,3
    tbl.push_back(mk(1, 1, 0, 8'd1, 4'b0001, 2'd0, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd2, 4'b0010, 2'd1, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd3, 4'b0100, 2'd2, 32'h00000001, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd3, 32'h00000102, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd3, 32'h00010203, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd3, 32'h00010203, 0, 0));
    // samples 1..6 with wrap
    tbl.push_back(mk(1, 1, 0, 8'd1, 4'b0001, 2'd0, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd2, 4'b0010, 2'd1, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd3, 4'b0100, 2'd2, 32'h00000001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd4, 4'b1000, 2'd3, 32'h00000102, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd5, 4'b0001, 2'd0, 32'h00010203, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd6, 4'b0010, 2'd1, 32'h01020304, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd2, 32'h02030405, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd2, 32'h03040506, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd2, 32'h03040506, 0, 1));
    // gapped 10,20,30
    tbl.push_back(mk(1, 1, 0, 8'd10, 4'b0001, 2'd0, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd1, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd1, 32'h0000000a, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd20, 4'b0010, 2'd1, 32'h0000000a, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd2, 32'h0000000a, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd2, 32'h00000a14, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd30, 4'b0100, 2'd2, 32'h00000a14, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd3, 32'h00000a14, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd3, 32'h000a141e, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0,  4'b0000, 2'd3, 32'h000a141e, 0, 0));
    // flush together with a sample after 5 samples
    tbl.push_back(mk(1, 1, 0, 8'd1, 4'b0001, 2'd0, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd2, 4'b0010, 2'd1, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'd3, 4'b0100, 2'd2, 32'h00000001, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd4, 4'b1000, 2'd3, 32'h00000102, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'd5, 4'b0001, 2'd0, 32'h00010203, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h55, 4'b1111, 2'd1, 32'h01020304, 1, 1));
    tbl.push_back(mk(0, 1, 0, 8'd9, 4'b0001, 2'd0, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd1, 32'h00000000, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd1, 32'h00000009, 1, 0));
    tbl.push_back(mk(0, 0, 0, 8'd0, 4'b0000, 2'd1, 32'h00000009, 0, 0));

    // Reset state while reset is held, with in_valid high
    in_valid = 1'b1; in_sample = 8'h77;
    #1;
    chk("reset cg_en", cg4, 0);
    chk("reset taps", taps4, 0);
    chk("reset tv/filled/wr_ptr", {tv4, f4, wp4}, 0);
    in_valid = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      in_valid = tbl[i].iv; flush = tbl[i].fl; in_sample = tbl[i].s;
      #1;
      chk($sformatf("row%0d cg_en", i), cg4, tbl[i].cg);
      chk($sformatf("row%0d reg_in", i), rin4, tbl[i].fl ? 32'h0 : {4{tbl[i].s}});
      chk($sformatf("row%0d wr_ptr", i), wp4, tbl[i].wp);
      chk($sformatf("row%0d taps_out", i), taps4, tbl[i].taps);
      chk($sformatf("row%0d taps_valid", i), tv4, tbl[i].tv);
      chk($sformatf("row%0d filled", i), f4, tbl[i].f);
    end

    // Asynchronous reset pulse mid-burst
    do_reset();
    for (int s = 1; s <= 4; s++) begin
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b0; in_sample = 8'(s);
    end
    #1;
    reset = 1'b0;
    #1;
    chk("async cg_en", cg4, 0);
    chk("async taps", taps4, 0);
    chk("async tv/filled/wr_ptr", {tv4, f4, wp4}, 0);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_sample = 8'd7;
    #1;
    chk("async next cg_en", cg4, 4'b0001);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("async next taps", taps4, 32'h00000007);
    chk("async next taps_valid", tv4, 1);

    // 16-tap random run against a shift-register model
    do_reset();
    m_hist = '0; m_taps = '0; m_pend = 0; m_tv = 0; m_filled = 0; m_cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      in_sample = 8'($urandom);
      #1;
      chk($sformatf("rand%0d taps_out", c), taps16, m_taps);
      chk($sformatf("rand%0d taps_valid", c), tv16, m_tv);
      chk($sformatf("rand%0d filled", c), f16, m_filled);
      if (flush) begin
        m_hist = '0; m_taps = '0; m_pend = 0; m_tv = 0; m_filled = 0; m_cnt = 0;
      end else begin
        m_filled = (m_cnt == 16);
        m_tv = m_pend;
        if (m_pend) m_taps = m_hist;
        m_pend = in_valid;
        if (in_valid) begin
          m_hist = {m_hist[119:0], in_sample};
          if (m_cnt < 16) m_cnt++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
